// File: rtl/fp_align_pkg.sv
// Shared types and helpers for the FP adder exponent-alignment stage.
// Default operand widths live here; fp_align_pipe takes its defaults from them.
package fp_align_pkg;

  localparam int FP_EXP_W   = 11;
  localparam int FP_MAN_W   = 53;
  localparam int GRS_W      = 3;
  localparam int FP_LIMIT   = FP_MAN_W + GRS_W;
  localparam int FP_SHAMT_W = $clog2(FP_LIMIT + 1);

  // Beyond 'limit' every significand bit has already landed in sticky,
  // so larger distances behave identically.
  function automatic logic [31:0] shamt_limit(input logic [31:0] mag, input logic [31:0] limit);
    return (mag >= limit) ? limit : mag;
  endfunction

  typedef struct packed {
    logic [FP_EXP_W-1:0]   exp;
    logic                  swap;
    logic [FP_SHAMT_W-1:0] shamt;
    logic                  sat;
    logic [FP_MAN_W-1:0]   man_big;
    logic [FP_MAN_W-1:0]   man_small;
  } s1_payload_t;

endpackage

// File: rtl/fp_align_pipe_if.sv
// Operand-in / aligned-result-out bus of the exponent-alignment stage.
// slave = the alignment stage itself, master = the unpack/adder side driving it.
interface fp_align_pipe_if
  import fp_align_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
);

  localparam int LIMIT   = MAN_W + GRS_W;
  localparam int SHAMT_W = $clog2(LIMIT + 1);

  // Both sides: a beat moves when valid && ready at a clk edge; a producer
  // holding valid keeps its payload stable until ready; in_ready may depend
  // combinationally on out_ready.
  logic               in_valid;
  logic               in_ready;
  logic [EXP_W-1:0]   in_exp_a;
  logic [EXP_W-1:0]   in_exp_b;
  logic [MAN_W-1:0]   in_man_a;
  logic [MAN_W-1:0]   in_man_b;
  logic               out_valid;
  logic               out_ready;
  logic [EXP_W-1:0]   out_exp;
  logic               out_swap;
  logic [LIMIT-1:0]   out_man_big;
  logic [LIMIT-1:0]   out_man_small;
  logic [SHAMT_W-1:0] out_shamt;
  logic               out_sat;

  modport slave (
    input  in_valid, in_exp_a, in_exp_b, in_man_a, in_man_b, out_ready,
    output in_ready, out_valid, out_exp, out_swap, out_man_big, out_man_small,
           out_shamt, out_sat
  );

  modport master (
    output in_valid, in_exp_a, in_exp_b, in_man_a, in_man_b, out_ready,
    input  in_ready, out_valid, out_exp, out_swap, out_man_big, out_man_small,
           out_shamt, out_sat
  );

endinterface

// File: rtl/fp_shamt_limit.sv
// Exponent comparison and saturated alignment distance, purely combinational.
module fp_shamt_limit
  import fp_align_pkg::*;
#(
  parameter int EXP_W   = FP_EXP_W,
  parameter int LIMIT   = FP_LIMIT,
  parameter int SHAMT_W = $clog2(LIMIT + 1)
) (
  input  logic [EXP_W-1:0]   exp_a,
  input  logic [EXP_W-1:0]   exp_b,
  output logic               swap,
  output logic [SHAMT_W-1:0] shamt,
  output logic               sat
);

  logic [EXP_W:0] diff_ab;
  logic [EXP_W:0] diff_ba;
  logic [EXP_W:0] mag;

  assign swap    = exp_b > exp_a;
  assign diff_ab = {1'b0, exp_a} - {1'b0, exp_b};
  assign diff_ba = {1'b0, exp_b} - {1'b0, exp_a};
  assign mag     = swap ? diff_ba : diff_ab;

  assign shamt = SHAMT_W'(shamt_limit(32'(mag), 32'(LIMIT)));
  assign sat   = 32'(mag) >= 32'(LIMIT);

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage exponent alignment: stage 1 compares/routes, stage 2 shifts with GRS+sticky.
// Optional FP_ALIGN_STATS_EN adds a saturating count of emitted saturated results.
module fp_align_pipe
  import fp_align_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input logic            clk,
  input logic            rst_n,
  fp_align_pipe_if.slave bus
`ifdef FP_ALIGN_STATS_EN
  ,
  output logic [15:0]    sat_count
`endif
);

  localparam int LIMIT   = MAN_W + GRS_W;
  localparam int SHAMT_W = $clog2(LIMIT + 1);

  logic               s1_valid;
  s1_payload_t        s1_q;
  s1_payload_t        s1_d;
  logic               s1_en;
  logic               s2_en;

  logic               lim_swap;
  logic [SHAMT_W-1:0] lim_shamt;
  logic               lim_sat;

  logic [LIMIT-1:0]   small_ext;
  logic [LIMIT-1:0]   shifted;
  logic [LIMIT-1:0]   lost_mask;
  logic               sticky;
  logic [LIMIT-1:0]   aligned;

  logic               res_valid;
  logic [EXP_W-1:0]   res_exp;
  logic               res_swap;
  logic [LIMIT-1:0]   res_man_big;
  logic [LIMIT-1:0]   res_man_small;
  logic [SHAMT_W-1:0] res_shamt;
  logic               res_sat;

  // Stages advance independently, so two items fit without bubbles.
  assign s2_en        = !res_valid || bus.out_ready;
  assign s1_en        = !s1_valid || s2_en;
  assign bus.in_ready = s1_en && rst_n;

  fp_shamt_limit #(
    .EXP_W   (EXP_W),
    .LIMIT   (LIMIT),
    .SHAMT_W (SHAMT_W)
  ) u_shamt_limit (
    .exp_a (bus.in_exp_a),
    .exp_b (bus.in_exp_b),
    .swap  (lim_swap),
    .shamt (lim_shamt),
    .sat   (lim_sat)
  );

  always_comb begin
    s1_d           = '0;
    s1_d.exp       = lim_swap ? bus.in_exp_b : bus.in_exp_a;
    s1_d.swap      = lim_swap;
    s1_d.shamt     = lim_shamt;
    s1_d.sat       = lim_sat;
    s1_d.man_big   = lim_swap ? bus.in_man_b : bus.in_man_a;
    s1_d.man_small = lim_swap ? bus.in_man_a : bus.in_man_b;
  end

  // A shift of LIMIT clears every bit and the mask covers the whole word,
  // which yields the sticky-only result without a special case.
  assign small_ext = {s1_q.man_small, {GRS_W{1'b0}}};
  assign shifted   = small_ext >> s1_q.shamt;
  assign lost_mask = ~({LIMIT{1'b1}} << s1_q.shamt);
  assign sticky    = |(small_ext & lost_mask);
  assign aligned   = {shifted[LIMIT-1:1], shifted[0] | sticky};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_q          <= '0;
      res_valid     <= 1'b0;
      res_exp       <= '0;
      res_swap      <= 1'b0;
      res_man_big   <= '0;
      res_man_small <= '0;
      res_shamt     <= '0;
      res_sat       <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (s2_en) begin
        res_valid <= s1_valid;
        if (s1_valid) begin
          res_exp       <= s1_q.exp;
          res_swap      <= s1_q.swap;
          res_man_big   <= {s1_q.man_big, {GRS_W{1'b0}}};
          res_man_small <= aligned;
          res_shamt     <= s1_q.shamt;
          res_sat       <= s1_q.sat;
        end
      end
    end
  end

  assign bus.out_valid     = res_valid;
  assign bus.out_exp       = res_exp;
  assign bus.out_swap      = res_swap;
  assign bus.out_man_big   = res_man_big;
  assign bus.out_man_small = res_man_small;
  assign bus.out_shamt     = res_shamt;
  assign bus.out_sat       = res_sat;

`ifdef FP_ALIGN_STATS_EN
  logic [15:0] sat_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (res_valid && bus.out_ready && res_sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  assign sat_count = sat_cnt;
`endif

endmodule

// File: tb/tb_fp_align_pipe.sv
// Bench for fp_align_pipe: directed plan steps plus randomized traffic against
// an arithmetic reference model and an in-order expected queue.
module tb_fp_align_pipe;

  localparam int EW       = 11;
  localparam int MW       = 53;
  localparam int XW       = MW + 3;
  localparam int SW       = $clog2(XW + 1);
  localparam int PW       = EW + 1 + SW + 1 + 2 * XW;
  localparam int SAT_BIT  = 2 * XW;
  localparam int N_RAND   = 300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_align_pipe_if #(.EXP_W(EW), .MAN_W(MW)) bus ();

`ifdef FP_ALIGN_STATS_EN
  logic [15:0] sat_count;
`endif

  fp_align_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FP_ALIGN_STATS_EN
    ,
    .sat_count (sat_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int sat_model = 0;
  logic [PW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Result as the spec describes it: pick the bigger exponent, distance
  // capped at 56, then a plain divide-by-shift with a lost-bits flag.
  function automatic logic [PW-1:0] model(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                                          input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    int a, b, mag, sh;
    logic sw, st;
    logic [XW-1:0] big, ext, al;
    a   = int'(ea);
    b   = int'(eb);
    sw  = (b > a);
    mag = sw ? (b - a) : (a - b);
    sh  = (mag < XW) ? mag : XW;
    st  = (mag >= XW);
    big = {(sw ? mb : ma), 3'b000};
    ext = {(sw ? ma : mb), 3'b000};
    if (sh == XW) begin
      al = (ext != '0) ? XW'(1) : '0;
    end else begin
      al = ext >> sh;
      if ((al << sh) != ext) al[0] = 1'b1;
    end
    return {(sw ? eb : ea), sw, SW'(sh), st, big, al};
  endfunction

  function automatic logic [PW-1:0] out_vec();
    return {bus.out_exp, bus.out_swap, bus.out_shamt, bus.out_sat, bus.out_man_big, bus.out_man_small};
  endfunction

  always @(negedge clk) begin : monitor
    logic [PW-1:0] e;
    if (rst_n === 1'b1) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        total++;
        assert (exp_q.size() > 0)
        else begin
          bad++;
          $error("FAIL unexpected_out observed=%0h expected=none", out_vec());
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("scoreboard", out_vec(), e);
          if (e[SAT_BIT] && sat_model < 65535) sat_model++;
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
        exp_q.push_back(model(bus.in_exp_a, bus.in_exp_b, bus.in_man_a, bus.in_man_b));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                      input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    bus.in_valid = 1'b1;
    bus.in_exp_a = ea;
    bus.in_exp_b = eb;
    bus.in_man_a = ma;
    bus.in_man_b = mb;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = (bus.in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", PW'(acc), PW'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", PW'(exp_q.size()), PW'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : stim
    logic [MW-1:0] hid;
    logic [MW-1:0] ma, mb;
    logic [EW-1:0] ea, eb;
    logic [63:0]   r;
    int            d, t;
    bit            rnd_done;

    hid           = {1'b1, {(MW-1){1'b0}}};
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_exp_a  = '0;
    bus.in_exp_b  = '0;
    bus.in_man_a  = '0;
    bus.in_man_b  = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", PW'(bus.out_valid), PW'(0));
    chk("rst_in_ready", PW'(bus.in_ready), PW'(0));
    chk("rst_out_vec", out_vec(), '0);
    settle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", PW'(bus.in_ready), PW'(1));
    settle();

    // plan 1: difference of one
    bus.out_ready = 1'b1;
    send(11'h400, 11'h3FF, hid, hid);
    @(negedge clk);
    chk("t1_latency_not_1", PW'(bus.out_valid), PW'(0));
    @(negedge clk);
    chk("t1_valid", PW'(bus.out_valid), PW'(1));
    chk("t1_swap", PW'(bus.out_swap), PW'(0));
    chk("t1_shamt", PW'(bus.out_shamt), PW'(1));
    chk("t1_sat", PW'(bus.out_sat), PW'(0));
    chk("t1_exp", PW'(bus.out_exp), PW'(11'h400));
    chk("t1_small", PW'(bus.out_man_small), PW'(XW'(1) << 54));
    settle();

    // plan 2: huge difference, swapped, sticky only
    mb = hid | MW'(5);
    send(11'h001, 11'h7FF, hid, mb);
    repeat (2) @(negedge clk);
    chk("t2_swap", PW'(bus.out_swap), PW'(1));
    chk("t2_shamt", PW'(bus.out_shamt), PW'(56));
    chk("t2_sat", PW'(bus.out_sat), PW'(1));
    chk("t2_exp", PW'(bus.out_exp), PW'(11'h7FF));
    chk("t2_small", PW'(bus.out_man_small), PW'(1));
    chk("t2_big", PW'(bus.out_man_big), PW'({mb, 3'b000}));
    settle();

    // plan 3: equal exponents
    ma = hid | MW'(36'h123456789);
    mb = MW'(56'h1F_FFFF_FFFF_FFFF);
    send(11'h3FF, 11'h3FF, ma, mb);
    repeat (2) @(negedge clk);
    chk("t3_shamt", PW'(bus.out_shamt), PW'(0));
    chk("t3_swap", PW'(bus.out_swap), PW'(0));
    chk("t3_sat", PW'(bus.out_sat), PW'(0));
    chk("t3_small", PW'(bus.out_man_small), PW'({mb, 3'b000}));
    chk("t3_big", PW'(bus.out_man_big), PW'({ma, 3'b000}));
    settle();

    // plan 4: sticky from a bit shifted past guard/round
    send(11'h408, 11'h400, hid, hid | MW'(16));
    repeat (2) @(negedge clk);
    chk("t4_shamt", PW'(bus.out_shamt), PW'(8));
    chk("t4_small", PW'(bus.out_man_small), PW'((XW'(1) << 47) | XW'(1)));
    settle();

    // saturation boundary around 56
    for (int k = 54; k <= 58; k++) begin
      send(11'd200, EW'(200 + k), hid | MW'(k), hid | MW'(3));
      repeat (2) @(negedge clk);
      chk("bnd_sat", PW'(bus.out_sat), PW'(k >= 56));
      chk("bnd_shamt", PW'(bus.out_shamt), PW'((k >= 56) ? 56 : k));
      settle();
    end
    drain();

    // plan 5: backpressure with three back-to-back items
    bus.out_ready = 1'b0;
    send(11'h300, 11'h2F0, hid | MW'(7), hid | MW'(9));
    send(11'h310, 11'h312, hid | MW'(11), hid | MW'(13));
    fork
      send(11'h320, 11'h320, hid | MW'(15), hid | MW'(17));
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", PW'(bus.in_ready), PW'(0));
          chk("bp_out_valid", PW'(bus.out_valid), PW'(1));
          chk("bp_hold_a", out_vec(), model(11'h300, 11'h2F0, hid | MW'(7), hid | MW'(9)));
        end
        settle();
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // random traffic with random downstream stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < N_RAND; i++) begin
          ea = EW'($urandom_range(0, 2047));
          if ($urandom_range(0, 2) == 0) begin
            eb = EW'($urandom_range(0, 2047));
          end else begin
            d = int'($urandom_range(0, 120)) - 60;
            t = int'(ea) + d;
            if (t < 0) t = 0;
            if (t > 2047) t = 2047;
            eb = EW'(t);
          end
          r  = {$urandom(), $urandom()};
          ma = r[MW-1:0];
          ma[MW-1] = ($urandom_range(0, 7) != 0);
          r  = {$urandom(), $urandom()};
          mb = r[MW-1:0];
          mb[MW-1] = ($urandom_range(0, 7) != 0);
          if ($urandom_range(0, 15) == 0) ma = '0;
          if ($urandom_range(0, 15) == 0) mb = '0;
          send(ea, eb, ma, mb);
          if ($urandom_range(0, 7) == 0) settle();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          settle();
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

`ifdef FP_ALIGN_STATS_EN
    chk("sat_count", PW'(sat_count), PW'(sat_model));
`endif

    // plan 6: reset with two items in flight
    bus.out_ready = 1'b0;
    send(11'h100, 11'h180, hid, hid | MW'(1));
    send(11'h222, 11'h221, hid | MW'(2), hid);
    rst_n = 1'b0;
    exp_q.delete();
    sat_model = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", PW'(bus.in_ready), PW'(0));
    settle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", PW'(bus.out_valid), PW'(0));
    chk("post_rst_vec", out_vec(), '0);
    chk("post_rst_in_ready", PW'(bus.in_ready), PW'(1));
`ifdef FP_ALIGN_STATS_EN
    chk("post_rst_sat_count", PW'(sat_count), PW'(0));
`endif
    settle();
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale", PW'(bus.out_valid), PW'(0));
    end
    settle();

    // pipeline recovers after reset
    send(11'h050, 11'h060, hid | MW'(255), hid);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Parametrised, pipelined exponent-alignment stage for the FP adder.
- Compares the exponents and selects the larger one.
- Saturates the exponent-difference shift amount to the useful limit.
- Right-shifts the smaller operand's significand with guard/round/sticky (GRS) bits.
- Sits between operand unpack and the significand adder; valid/ready on both sides.

Parameters:
EXP_W, 11, exponent field width
MAN_W, 53, significand width including hidden bit
LIMIT (localparam), MAN_W+3, maximum useful shift (all bits into GRS)
SHAMT_W (localparam), $clog2(LIMIT+1), shift-amount width (6 at defaults)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  stage can accept
in_exp_a  in  EXP_W  exponent A
in_exp_b  in  EXP_W  exponent B
in_man_a  in  MAN_W  significand A
in_man_b  in  MAN_W  significand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_exp  out  EXP_W  larger exponent
out_swap  out  1  1 when exp_b > exp_a
out_man_big  out  MAN_W+3  larger operand's significand, {man,3'b000}
out_man_small  out  MAN_W+3  aligned smaller operand's significand; LSB is sticky-ORed
out_shamt  out  SHAMT_W  saturated shift amount
out_sat  out  1  1 when |diff| >= LIMIT

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Stage 1 (registered), on acceptance:
  - swap = exp_b > exp_a.
  - mag = |exp_a - exp_b|, computed at EXP_W+1 bits.
  - shamt = min(mag, LIMIT); sat = (mag >= LIMIT).
  - Operands are routed big/small according to swap.
- Stage 2 (registered):
  - small = {man_small, 3'b000} >> shamt.
  - sticky = OR of all bits shifted out; sticky is ORed into bit 0.
  - When shamt == LIMIT: all bits shifted out; result = {0.., |man_small}.
- Equal exponents: swap=0, shamt=0, sat=0, out_man_small = man_b<<3.
- Latency is exactly 2 cycles from accepted input to out_valid when unstalled; throughput is 1 per cycle.
- Handshake:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en && rst_n. This path is combinational from out_ready (documented).
  - Transfer occurs when valid && ready.
  - While out_valid && !out_ready, all out_* hold stable.
  - Capacity is 2 items; in_ready deasserts only when both stages are full and out_ready=0.
- Reset (rst_n low at a clk edge):
  - All valid flags and all data/output registers go to 0.
  - In-flight items are discarded and in_ready=0 during reset.
  - Reset mid-operation has the same effect.
- Simultaneous events: accept and emit in the same cycle is allowed; there are no bubbles.

Optional Feature:
- Macro: FP_ALIGN_STATS_EN.
- When defined:
  - Adds output port sat_count [15:0].
  - The counter increments on each output transfer with out_sat=1.
  - It saturates at 16'hFFFF and resets to 0.
- When undefined: the port and counter are absent. Datapath behaviour is identical in both builds.

Decomposition:
- Package fp_align_pkg:
  - GRS_W=3.
  - Function shamt_limit(mag, limit).
  - Typedef struct for the stage-1 payload (exp, swap, shamt, sat, man_big, man_small).
- Sub-module fp_shamt_limit: combinational comparison and saturation (generalised exponent-difference limiter). Instanced in stage 1.
- The stage-2 sticky shifter stays inline.

Test Plan:
1. exp_a=0x400, exp_b=0x3FF, man_a=man_b=1<<52, out_ready=1 -> 2 cycles later:
   - out_swap=0, out_shamt=1, out_sat=0, out_exp=0x400.
   - out_man_small=1<<54.
2. exp_a=0x001, exp_b=0x7FF, man_a=1<<52 ->
   - out_swap=1, out_shamt=56, out_sat=1, out_exp=0x7FF.
   - out_man_small=1 (sticky only).
3. exp_a=exp_b=0x3FF, man_b=0x1F_FFFF_FFFF_FFFF ->
   - shamt=0, swap=0.
   - out_man_small=man_b<<3, out_man_big=man_a<<3.
4. Sticky: exp_a=0x408, exp_b=0x400, man_b=(1<<52)|0x10 ->
   - shamt=8.
   - out_man_small=(1<<47)|1.
5. Backpressure: three back-to-back inputs (A, B, C), out_ready=0 for 4 cycles ->
   - A held on outputs; in_ready=0 once A and B are held.
   - C accepted after out_ready=1.
   - Order A, B, C preserved; no drops or duplicates.
6. Reset mid-flight: rst_n=0 for one cycle with 2 items in flight ->
   - Next cycle out_valid=0 and outputs 0; in_ready=1 after release.
   - No stale output.
   - With FP_ALIGN_STATS_EN: sat_count=0.
